clz_count_unit: RTL
===================

Name: clz_count_unit

Overview:
- Multi-cycle count-leading-zeros/ones unit for the MIPS datapath; implements CLZ and CLO.
- Determines the shift amount that normalises a word, i.e. the inverse of the shift unit. Also returns the normalised word.
- Sits beside the ALU/shift unit. The control FSM issues `start` and stalls on `busy` until `done`.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; `count` is 6 bits wide.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled on the rising edge.
- `mode`  in  1  0 = CLZ (count leading zeros), 1 = CLO (count leading ones).
- `src`  in  32  operand; sampled with `start`.
- `busy`  out  1  high while a count is in progress.
- `done`  out  1  one-cycle pulse; result valid.
- `count`  out  6  leading zero/one count, 0..32.
- `norm_out`  out  32  original `src` shifted left logically by `count`.

Behaviour:
- One clock; reset is synchronous and active-high on `reset`, sampled at the `clock` rising edge.
- Reset (including mid-operation):
  - state goes to IDLE;
  - `busy`, `done`, `count`, `norm_out` all become 0;
  - any in-flight operation is discarded, with no `done`.
- FSM states:
  - IDLE → SCAN when `start`=1: latch `work` = (`mode` ? ~`src` : `src`), `shadow` = `src`, `cnt` = 0.
  - SCAN: each cycle, if `work[31]`=1 or `cnt`=32, go to DONE. On that edge, register `count` = `cnt` and `norm_out` = `shadow`. Otherwise `work` <<= 1, `shadow` <<= 1, `cnt` += 1.
  - DONE: `done` = 1 for exactly one cycle, then go to IDLE. If `start`=1 is sampled in DONE, go directly to SCAN with the new operand (back-to-back issue).
- `busy` = 1 in SCAN, 0 in IDLE and DONE.
- `start` while in SCAN is ignored; the operation is not restarted.
- Latency: `done` is high n+1 cycles after the edge that samples `start`, where n is the result count. Maximum is 33 cycles, for n=32.
- `count` and `norm_out` hold their last result until the next DONE or reset. They do not change during SCAN.
- Arithmetic and width rules:
  - all shifts are logical (zero fill);
  - `cnt` is 6 bits unsigned and saturates at 32; no wrap;
  - for n=32, `norm_out` = 0.
- CLO is evaluated on the inverted copy; `norm_out` is always derived from the non-inverted `src`.
- `mode` and `src` are ignored except on the accepting edge.

Optional Feature:
- Macro: CLZ_NIBBLE_STEP_EN.
- Defined: SCAN examines `work[31:28]` each cycle.
  - If `work[31:28]`=0 and `cnt`<32: shift `work` and `shadow` by 4 and set `cnt` += 4.
  - Otherwise: add the leading-zero count of the nibble (0..3) to `cnt`, apply the same extra shift to `shadow`, and go to DONE in the same edge.
  - Latency = floor(n/4)+1 cycles; maximum 9.
- Undefined: 1 bit per cycle as specified above.
- Results (`count`, `norm_out`) are identical in both builds; only latency differs.

Test Plan:
- CLZ of `src`=0x8000_0000 → `done` 1 cycle after start; `count`=0, `norm_out`=0x8000_0000.
- CLZ of `src`=0x0000_1234 → `count`=19, `norm_out`=0x91A0_0000, `done` at cycle 20 (nibble build: cycle 5).
- CLZ of `src`=0x0000_0000 → `count`=32, `norm_out`=0, `done` at cycle 33 (nibble build: 9). `busy` is high throughout SCAN.
- CLO of `src`=0xFFF0_0000 → `count`=12, `norm_out`=0x0000_0000. CLO of `src`=0x0000_0001 → `count`=0, `norm_out`=0x0000_0001.
- Pulse `start` with 0xFFFF_FFFF mid-SCAN of CLZ 0x0000_00FF → ignored; `count`=24, `norm_out`=0xFF00_0000. Then issue `start` in the DONE cycle → second result follows with no IDLE gap.
- Assert `reset` at cycle 10 of CLZ 0 → next cycle `busy`=0, `count`=0, `norm_out`=0; no `done` pulse ever appears for that operation.

Source files
------------

// File: rtl/clz_count_unit.sv
// Multi-cycle CLZ/CLO unit: counts leading zeros (mode=0) or ones (mode=1)
// of src, and returns src shifted left by that count (normalised word).
// Ports: clock, reset (sync, active-high), start, mode, src[31:0] in;
//        busy, done (1-cycle pulse), count[5:0], norm_out[31:0] out.
// Build option: CLZ_NIBBLE_STEP_EN scans 4 bits per cycle instead of 1.
module clz_count_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] src,
   output logic             busy,
   output logic             done,
   output logic [5:0]       count,
   output logic [WIDTH-1:0] norm_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_e;

   localparam logic [5:0] CNT_MAX = 6'd32;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [5:0]       count_q, count_d;
   logic [WIDTH-1:0] norm_q, norm_d;
   logic             accept;

`ifdef CLZ_NIBBLE_STEP_EN
   logic [3:0] nib;
   logic [1:0] nib_lz;
   logic [5:0] extra;

   // Leading zeros inside a non-zero top nibble.
   always_comb begin
      nib = work_q[WIDTH-1 -: 4];
      priority case (1'b1)
         nib[3]:  nib_lz = 2'd0;
         nib[2]:  nib_lz = 2'd1;
         nib[1]:  nib_lz = 2'd2;
         default: nib_lz = 2'd3;
      endcase
      // Once saturated the nibble is all-zero; add nothing more.
      extra = (cnt_q == CNT_MAX) ? 6'd0 : {4'd0, nib_lz};
   end
`endif

   // A new operand is taken from IDLE, and from DONE for back-to-back issue.
   assign accept = start && (state_q != S_SCAN);

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      count_d  = count_q;
      norm_d   = norm_q;

      unique case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_DONE: state_d = S_IDLE;
         S_SCAN: begin
`ifdef CLZ_NIBBLE_STEP_EN
            if (work_q[WIDTH-1 -: 4] == 4'd0 && cnt_q < CNT_MAX) begin
               work_d   = work_q << 4;
               shadow_d = shadow_q << 4;
               cnt_d    = cnt_q + 6'd4;
            end else begin
               state_d = S_DONE;
               count_d = cnt_q + extra;
               norm_d  = shadow_q << extra;
            end
`else
            if (work_q[WIDTH-1] || cnt_q == CNT_MAX) begin
               state_d = S_DONE;
               count_d = cnt_q;
               norm_d  = shadow_q;
            end else begin
               work_d   = work_q << 1;
               shadow_d = shadow_q << 1;
               cnt_d    = cnt_q + 6'd1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         state_d  = S_SCAN;
         // CLO is a CLZ of the inverted word; shadow keeps the true src.
         work_d   = mode ? ~src : src;
         shadow_d = src;
         cnt_d    = 6'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         work_q   <= '0;
         shadow_q <= '0;
         cnt_q    <= 6'd0;
         count_q  <= 6'd0;
         norm_q   <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         count_q  <= count_d;
         norm_q   <= norm_d;
      end
   end

   assign busy     = (state_q == S_SCAN);
   assign done     = (state_q == S_DONE);
   assign count    = count_q;
   assign norm_out = norm_q;

endmodule
